// File: rtl/key_note_pkg.sv
// Shared types, constants and the note priority encoder for the key/note front end.
package key_note_pkg;

  localparam int unsigned NOTE_W       = 4;
  localparam int unsigned KEYS_PER_OCT = 7;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'h0;

  typedef enum logic {
    ST_IDLE,
    ST_SOUNDING
  } note_state_t;

  // Lowest-numbered key that is down wins; code is 1 + its index, NOTE_NONE if none.
  function automatic logic [NOTE_W-1:0] prio_enc(input logic [KEYS_PER_OCT-1:0] keys);
    logic [NOTE_W-1:0] code;
    logic              found;
    code  = NOTE_NONE;
    found = 1'b0;
    for (int unsigned i = 0; i < KEYS_PER_OCT; i++) begin
      if (keys[i] && !found) begin
        code  = NOTE_W'(i + 1);
        found = 1'b1;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/key_note_encoder_if.sv
// Key inputs and note outputs of the piano front end, bundled for the datapath.
interface key_note_if;
  import key_note_pkg::*;

  logic [KEYS_PER_OCT-1:0] key_med;
  logic [KEYS_PER_OCT-1:0] key_low;
  logic [NOTE_W-1:0]       med;
  logic [NOTE_W-1:0]       low;
  logic                    note_on;
  logic                    note_off;

  // Key source side (buttons / stimulus).
  modport master (
    output key_med, key_low,
    input  med, low, note_on, note_off
  );

  // Encoder side.
  modport slave (
    input  key_med, key_low,
    output med, low, note_on, note_off
  );

endinterface

// File: rtl/key_debounce.sv
// One key: polarity normalisation, 2-flop synchroniser and tick-sampled debounce.
module key_debounce #(
  parameter int unsigned DB_SAMPLES  = 4,
  parameter bit          KEY_ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_db
);

  logic                  key_norm;
  logic                  sync1;
  logic                  sync2;
  logic [DB_SAMPLES-1:0] hist;
  logic [DB_SAMPLES-1:0] hist_nxt;

  assign key_norm = KEY_ACT_LOW ? ~key_raw : key_raw;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key_norm;
      sync2 <= sync1;
    end
  end

  // History after this tick's sample is shifted in.
  always_comb begin
    hist_nxt = {hist[DB_SAMPLES-2:0], sync2};
  end

  // On each tick record a sample; change state only on a unanimous history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      key_db <= 1'b0;
    end else if (tick) begin
      hist <= hist_nxt;
      if (&hist_nxt) begin
        key_db <= 1'b1;
      end else if (~|hist_nxt) begin
        key_db <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_note_encoder.sv
// Piano front end: debounces 14 keys, priority-encodes mid/low note codes and
// emits note_on/note_off strobes aligned with the registered code.
module key_note_encoder
  import key_note_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DB_SAMPLES  = 4,
  parameter bit          KEY_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  key_note_if.slave  bus
);

  localparam int unsigned NKEYS = 2 * KEYS_PER_OCT;
  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0]     tick_cnt;
  logic                 tick;
  logic [NKEYS-1:0]     raw_keys;
  logic [NKEYS-1:0]     db_keys;
  logic [NOTE_W-1:0]    m_code;
  logic [NOTE_W-1:0]    l_code;
  logic [NOTE_W-1:0]    med_q;
  logic [NOTE_W-1:0]    low_q;
  logic [2*NOTE_W-1:0]  nxt_code;
  logic [2*NOTE_W-1:0]  cur_code;
  logic                 on_q;
  logic                 off_q;
  logic                 on_d;
  logic                 off_d;
  note_state_t          state;
  note_state_t          state_nxt;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running debounce sample divider, 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign raw_keys = {bus.key_low, bus.key_med};

  for (genvar g = 0; g < NKEYS; g++) begin : g_key
    key_debounce #(
      .DB_SAMPLES  (DB_SAMPLES),
      .KEY_ACT_LOW (KEY_ACT_LOW)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .key_raw (raw_keys[g]),
      .key_db  (db_keys[g])
    );
  end

  // Mid octave always beats low octave.
  always_comb begin
    m_code = prio_enc(db_keys[KEYS_PER_OCT-1:0]);
    l_code = NOTE_NONE;
    if (m_code == NOTE_NONE) begin
      l_code = prio_enc(db_keys[NKEYS-1:KEYS_PER_OCT]);
    end
  end

  assign nxt_code = {m_code, l_code};
  assign cur_code = {med_q, low_q};

  // State, note codes and strobes all update together so strobes line up with the new code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      med_q <= NOTE_NONE;
      low_q <= NOTE_NONE;
      on_q  <= 1'b0;
      off_q <= 1'b0;
    end else begin
      state <= state_nxt;
      med_q <= m_code;
      low_q <= l_code;
      on_q  <= on_d;
      off_q <= off_d;
    end
  end

  // Sounding whenever the incoming code is non-empty.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:     if (nxt_code != '0) state_nxt = ST_SOUNDING;
      ST_SOUNDING: if (nxt_code == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Strobe decode: a changed non-empty code retriggers without an intervening note_off.
  always_comb begin
    on_d  = 1'b0;
    off_d = 1'b0;
    unique case (state)
      ST_IDLE: on_d = (nxt_code != '0);
      ST_SOUNDING: begin
        if (nxt_code == '0) begin
          off_d = 1'b1;
        end else if (nxt_code != cur_code) begin
          on_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.med      = med_q;
  assign bus.low      = low_q;
  assign bus.note_on  = on_q;
  assign bus.note_off = off_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// Directed and random checks of key_note_encoder (TICK_DIV=4, DB_SAMPLES=3, active-low keys).
module tb_key_note_encoder;

  localparam int unsigned BOUND = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  key_note_if bus();

  key_note_encoder #(
    .TICK_DIV    (4),
    .DB_SAMPLES  (3),
    .KEY_ACT_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model of the expected behaviour, index 0..6 = mid keys, 7..13 = low keys.
  logic [13:0] m_s1, m_s2, m_db;
  logic [2:0]  m_hist [14];
  int unsigned m_cnt;
  logic [3:0]  m_med, m_low, m_m, m_l;
  logic        m_on, m_off;
  logic [13:0] m_raw;

  assign m_raw = {bus.key_low, bus.key_med};

  always_comb begin
    m_m = 4'd0;
    m_l = 4'd0;
    for (int i = 6; i >= 0; i--) if (m_db[i]) m_m = 4'(i + 1);
    if (m_m == 4'd0)
      for (int i = 6; i >= 0; i--) if (m_db[7+i]) m_l = 4'(i + 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1  <= '0;
      m_s2  <= '0;
      m_db  <= '0;
      m_cnt <= 0;
      for (int k = 0; k < 14; k++) m_hist[k] <= '0;
      m_med <= '0;
      m_low <= '0;
      m_on  <= 1'b0;
      m_off <= 1'b0;
    end else begin
      m_s1  <= ~m_raw;
      m_s2  <= m_s1;
      m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
      if (m_cnt == 3) begin
        for (int k = 0; k < 14; k++) begin
          m_hist[k] <= {m_hist[k][1:0], m_s2[k]};
          if ({m_hist[k][1:0], m_s2[k]} == 3'b111) m_db[k] <= 1'b1;
          else if ({m_hist[k][1:0], m_s2[k]} == 3'b000) m_db[k] <= 1'b0;
        end
      end
      m_med <= m_m;
      m_low <= m_l;
      m_on  <= ({m_m, m_l} != 8'd0) && ({m_m, m_l} != {m_med, m_low});
      m_off <= ({m_m, m_l} == 8'd0) && ({m_med, m_low} != 8'd0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Step up to 'bound' cycles until the code appears, counting strobes on the way.
  task automatic wait_code(input string tag, input logic [3:0] em, input logic [3:0] el,
                           input int unsigned exp_on, input int unsigned exp_off);
    int unsigned n_on = 0;
    int unsigned n_off = 0;
    bit hit = 1'b0;
    for (int unsigned c = 0; c < BOUND && !hit; c++) begin
      @(negedge clk);
      n_on  += bus.note_on;
      n_off += bus.note_off;
      if (bus.med == em && bus.low == el) hit = 1'b1;
    end
    check({tag, "_reached"}, hit, 1);
    check({tag, "_med"}, bus.med, em);
    check({tag, "_low"}, bus.low, el);
    check({tag, "_on_cnt"}, n_on, exp_on);
    check({tag, "_off_cnt"}, n_off, exp_off);
  endtask

  task automatic check_idle_out(input string tag);
    check(tag, {bus.med, bus.low, bus.note_on, bus.note_off}, 0);
  endtask

  initial begin
    logic [13:0] held;
    logic [13:0] glitch;
    logic        prev_strobe;
    int unsigned strobes;
    logic        any_out;
    int unsigned r;

    bus.key_med = 7'h7F;
    bus.key_low = 7'h7F;

    // Reset held with all keys released.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle_out("reset_hold");
    end
    rst_n = 1'b1;

    // Clean press/release of mid key 3.
    bus.key_med[2] = 1'b0;
    wait_code("press_m3", 4'd3, 4'd0, 1, 0);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      strobes += bus.note_on + bus.note_off;
    end
    check("hold_m3_med", bus.med, 3);
    check("hold_m3_strobes", strobes, 0);
    bus.key_med[2] = 1'b1;
    wait_code("release_m3", 4'd0, 4'd0, 0, 1);

    // Bounce on low key 1 shorter than the debounce window.
    strobes = 0;
    any_out = 1'b0;
    for (int unsigned c = 0; c < 60; c++) begin
      if (c < 40) bus.key_low[0] = ((c / 5) % 2 == 0) ? 1'b0 : 1'b1;
      else        bus.key_low[0] = 1'b1;
      @(negedge clk);
      strobes += bus.note_on + bus.note_off;
      if (bus.low != 0 || bus.med != 0) any_out = 1'b1;
    end
    check("bounce_out", any_out, 0);
    check("bounce_strobes", strobes, 0);

    // Priority: mid beats low; lower index beats higher.
    bus.key_low[4] = 1'b0;
    bus.key_med[6] = 1'b0;
    wait_code("prio_m7", 4'd7, 4'd0, 1, 0);
    bus.key_med[1] = 1'b0;
    wait_code("prio_m2", 4'd2, 4'd0, 1, 0);
    bus.key_med[1] = 1'b1;
    wait_code("prio_back_m7", 4'd7, 4'd0, 1, 0);
    bus.key_med[6] = 1'b1;
    wait_code("prio_to_l5", 4'd0, 4'd5, 1, 0);
    bus.key_low[4] = 1'b1;
    wait_code("prio_off", 4'd0, 4'd0, 0, 1);

    // Mid-to-low handover.
    bus.key_low[3] = 1'b0;
    wait_code("hand_l4", 4'd0, 4'd4, 1, 0);
    bus.key_med[0] = 1'b0;
    wait_code("hand_m1", 4'd1, 4'd0, 1, 0);
    bus.key_med[0] = 1'b1;
    wait_code("hand_back_l4", 4'd0, 4'd4, 1, 0);
    bus.key_low[3] = 1'b1;
    wait_code("hand_off", 4'd0, 4'd0, 0, 1);

    // Reset mid-note, key still held through and after reset.
    bus.key_med[4] = 1'b0;
    wait_code("pre_rst_m5", 4'd5, 4'd0, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_out("rst_mid_note");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_out("rst_mid_hold");
    end
    rst_n = 1'b1;
    wait_code("post_rst_m5", 4'd5, 4'd0, 1, 0);
    bus.key_med[4] = 1'b1;
    wait_code("post_rst_off", 4'd0, 4'd0, 0, 1);

    // Random bouncy keys against the reference model.
    held = '0;
    prev_strobe = 1'b0;
    for (int unsigned cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      check("rnd_out", {bus.med, bus.low, bus.note_on, bus.note_off},
            {m_med, m_low, m_on, m_off});
      check("rnd_med_low_excl", (bus.med != 0) && (bus.low != 0), 0);
      check("rnd_on_off_excl", bus.note_on & bus.note_off, 0);
      check("rnd_consec_strobe", (bus.note_on | bus.note_off) & prev_strobe, 0);
      prev_strobe = bus.note_on | bus.note_off;
      r = $urandom_range(0, 99);
      glitch = '0;
      if (r < 3) held[$urandom_range(0, 13)] ^= 1'b1;
      else if (r < 10) glitch[$urandom_range(0, 13)] = 1'b1;
      else if (r == 99) held = '0;
      {bus.key_low, bus.key_med} = ~(held ^ glitch);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
